// File: rtl/score_pkg.sv
// Shared definitions for the score display path: FSM states, BCD digit width
// and the iteration counter width helper.
package score_pkg;

    localparam int unsigned BCD_DIGIT_W     = 4;
    localparam int unsigned DEF_BIN_WIDTH   = 14;
    localparam int unsigned DEF_ITER_CNT_W  = $clog2(DEF_BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int unsigned iter_cnt_width(input int unsigned bin_width);
        return $clog2(bin_width + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the
// shift so that doubling it carries correctly into the next digit.
module bcd_digit_adjust
    import score_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_DIGIT_W'(5))
            dout = din + BCD_DIGIT_W'(3);
    end

endmodule

// File: rtl/score_bcd_encoder.sv
// Iterative binary-to-BCD converter (one bit per clock) for the score display.
// Optional build macro SCORE_BCD_SATURATE_EN clamps out-of-range scores to all nines.
module score_bcd_encoder
    import score_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = 14,
    parameter int unsigned DIGITS    = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [BIN_WIDTH-1:0]          bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] digits,
    output logic                          overflow
);

    localparam int unsigned ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = iter_cnt_width(BIN_WIDTH);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BIN_WIDTH-1:0] sreg;
    logic [BIN_WIDTH-1:0] sreg_next;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_adj;
    logic [ACC_W-1:0]    acc_next;
    logic [ACC_W-1:0]    result;
    logic                carry;
    logic                carry_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The bit leaving the top digit has weight 10^DIGITS; it is only remembered.
    always_comb begin
        acc_next   = {acc_adj[ACC_W-2:0], sreg[BIN_WIDTH-1]};
        sreg_next  = {sreg[BIN_WIDTH-2:0], 1'b0};
        carry_next = carry | acc_adj[ACC_W-1];
`ifdef SCORE_BCD_SATURATE_EN
        result     = carry_next ? {DIGITS{4'h9}} : acc_next;
`else
        result     = acc_next;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            sreg     <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            digits   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sreg  <= bin_in;
                        acc   <= '0;
                        carry <= 1'b0;
                        cnt   <= CNT_W'(BIN_WIDTH);
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc   <= acc_next;
                    sreg  <= sreg_next;
                    carry <= carry_next;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        digits   <= result;
                        overflow <= carry_next;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_encoder.sv
// Scoreboard bench for score_bcd_encoder: expected digits/overflow are queued at
// launch and compared when done pulses; digits must hold steady in between.
module tb_score_bcd_encoder;

    localparam int unsigned BIN_W = 14;
    localparam int unsigned NDIG  = 4;

    typedef struct {
        logic [15:0] digits;
        logic        ovf;
    } exp_t;

    logic              clk;
    logic              resetn;
    logic              start;
    logic [BIN_W-1:0]  bin_in;
    logic              busy;
    logic              done;
    logic [4*NDIG-1:0] digits;
    logic              overflow;

    exp_t        exp_q[$];
    logic [15:0] held_digits;
    int          n_checks;
    int          n_pass;

    score_bcd_encoder #(
        .BIN_WIDTH (BIN_W),
        .DIGITS    (NDIG)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .digits   (digits),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned r;
        r = v % 10000;
        e.digits = '0;
        for (int i = 0; i < 4; i++) begin
            e.digits[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        e.ovf = (v >= 10000);
`ifdef SCORE_BCD_SATURATE_EN
        if (e.ovf)
            e.digits = 16'h9999;
`endif
        return e;
    endfunction

    // Output monitor: compare on done, enforce hold otherwise.
    always @(negedge clk) begin
        if (!resetn) begin
            held_digits = '0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("digits", 32'(digits), 32'(e.digits));
                check("overflow", 32'(overflow), 32'(e.ovf));
                held_digits = e.digits;
            end
        end else begin
            check("digits_hold", 32'(digits), 32'(held_digits));
        end
    end

    // Drive start for one accepting edge; returns #1 after that edge.
    task automatic launch(input int unsigned v, input bit track);
        bin_in = BIN_W'(v);
        start  = 1'b1;
        if (track)
            exp_q.push_back(model(v));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called #1 after an edge; counts edges to done and busy samples on the way,
    // then steps one more edge to confirm the done pulse is a single cycle.
    task automatic wait_done(input int exp_lat, input int exp_busy, input string tag);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy)
                busy_cnt++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        held_digits = '0;
        resetn      = 1'b1;
        start       = 1'b0;
        bin_in      = '0;
        #2 resetn = 1'b0;
        #1;
        check("rst_digits", 32'(digits), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        launch(0, 1);
        wait_done(14, 14, "zero");
        launch(1234, 1);
        wait_done(14, 14, "v1234");
        launch(9999, 1);
        wait_done(14, 14, "v9999");
        launch(12345, 1);
        wait_done(14, 14, "v12345");
        launch(16383, 1);
        wait_done(14, 14, "vmax");
        launch(10000, 1);
        wait_done(14, 14, "v10000");

        // A start pulse while busy must be dropped.
        launch(42, 1);
        repeat (4) @(posedge clk);
        #1;
        bin_in = BIN_W'(77);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(9, 9, "ignore");
        repeat (20) @(posedge clk);
        #1;

        // Reset in the middle of a conversion clears outputs and yields no done.
        launch(5678, 0);
        repeat (6) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midrst_digits", 32'(digits), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        launch(31, 1);
        wait_done(14, 14, "v31");

        // start held high: second acceptance lands 16 edges after the first.
        exp_q.push_back(model(100));
        exp_q.push_back(model(200));
        bin_in = BIN_W'(100);
        start  = 1'b1;
        @(posedge clk);
        #1;
        bin_in = BIN_W'(200);
        wait_done(14, 14, "b2b_first");
        check("b2b_idle_gap", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("b2b_second_accept", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(14, 14, "b2b_second");

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
